// File: rtl/staged_mac_vec_pkg.sv
// Shared width helpers and saturation classification for the staged multi-lane MAC.
package staged_mac_vec_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int FRAC_BITS_DEF  = 16;
    localparam int NUM_LANES_DEF  = 4;
    localparam int ACCUM_BITS_DEF = 8;
    localparam int ID_WIDTH       = 8;

    typedef enum logic [1:0] {
        SAT_PASS,
        SAT_HI,
        SAT_LO
    } sat_e;

    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int sum_w(input int dw, input int lanes);
        return 2 * dw + $clog2(lanes);
    endfunction

    function automatic int acc_w(input int dw, input int lanes, input int guard_bits);
        return sum_w(dw, lanes) + guard_bits;
    endfunction

    // in_range means every bit above the output MSB equals the sign bit.
    function automatic sat_e sat_kind(input logic sign_bit, input logic in_range);
        if (in_range) begin
            return SAT_PASS;
        end
        return sign_bit ? SAT_LO : SAT_HI;
    endfunction

endpackage

// File: rtl/staged_mac_vec_if.sv
// AXI-Stream style bundle used on both the lane input and the result output.
interface staged_mac_vec_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tuser;
    logic              tvalid;
    logic [ID_W-1:0]   tid;
    logic              tready;

    modport master (output tdata, tlast, tuser, tvalid, tid, input tready);
    modport slave  (input tdata, tlast, tuser, tvalid, tid, output tready);
endinterface

// File: rtl/staged_mac_vec_adder_tree.sv
// Signed reduction tree over NUM_IN lane products with a single registered output.
module mac_adder_tree #(
    parameter int IN_W   = 64,
    parameter int OUT_W  = 66,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_IN*IN_W-1:0]  in_flat,
    output logic signed [OUT_W-1:0] sum_reg
);

    // Heap layout: leaves at NUM_IN-1.., node k sums children 2k+1 and 2k+2.
    logic signed [OUT_W-1:0] node [2*NUM_IN-1];

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            node[NUM_IN-1+i] = OUT_W'($signed(in_flat[i*IN_W +: IN_W]));
        end
        for (int i = NUM_IN - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (en) begin
            sum_reg <= node[0];
        end
    end

endmodule

// File: rtl/staged_mac_vec.sv
// Multi-lane staged fixed-point MAC: S0 reg, S1 multiply, S2 tree, S3 accumulate, output reg.
// Define STAGED_MAC_VEC_SAT_EN to saturate the result instead of wrapping.
module staged_mac_vec
    import staged_mac_vec_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int NUM_LANES  = NUM_LANES_DEF,
    parameter int ACCUM_BITS = ACCUM_BITS_DEF
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    staged_mac_vec_if.slave  sd_axis,
    staged_mac_vec_if.master mo_axis
);

    localparam int LANE_W  = 2 * DATA_WIDTH;
    localparam int BEAT_W  = NUM_LANES * LANE_W;
    localparam int PROD_W  = prod_w(DATA_WIDTH);
    localparam int SUM_W   = sum_w(DATA_WIDTH, NUM_LANES);
    localparam int ACC_W   = acc_w(DATA_WIDTH, NUM_LANES, ACCUM_BITS);
    localparam int OUT_MSB = FRAC_BITS + DATA_WIDTH - 1;

    logic en, accept, ready_reg;

    logic                       s0_valid_reg, s0_last_reg, s0_user_reg;
    logic [BEAT_W-1:0]          s0_data_reg;
    logic [ID_WIDTH-1:0]        s0_tid_reg;

    logic                       s1_valid_reg, s1_last_reg, s1_user_reg;
    logic [ID_WIDTH-1:0]        s1_tid_reg;
    logic signed [PROD_W-1:0]   s1_bias_reg;
    logic [NUM_LANES*PROD_W-1:0] s1_prod_flat;

    logic                       s2_valid_reg, s2_last_reg, s2_user_reg;
    logic [ID_WIDTH-1:0]        s2_tid_reg;
    logic signed [PROD_W-1:0]   s2_bias_reg;
    logic signed [SUM_W-1:0]    s2_sum;

    logic                       s3_valid_reg, first_beat_reg;
    logic [ID_WIDTH-1:0]        s3_tid_reg;
    logic signed [ACC_W-1:0]    acc_reg, acc_base, acc_next;

    logic                       mo_valid_reg;
    logic [DATA_WIDTH-1:0]      mo_data_reg, out_next;
    logic [ID_WIDTH-1:0]        mo_tid_reg;

    // One enable freezes the whole pipeline while a result waits for the writer.
    assign en              = !mo_valid_reg || mo_axis.tready;
    assign sd_axis.tready  = en && ready_reg;
    assign accept          = sd_axis.tvalid && sd_axis.tready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_reg    <= 1'b0;
            s0_valid_reg <= 1'b0;
            s0_last_reg  <= 1'b0;
            s0_user_reg  <= 1'b0;
            s0_data_reg  <= '0;
            s0_tid_reg   <= '0;
        end else begin
            ready_reg <= 1'b1;
            if (en) begin
                s0_valid_reg <= accept;
                if (accept) begin
                    s0_last_reg <= sd_axis.tlast;
                    s0_user_reg <= sd_axis.tuser;
                    s0_data_reg <= sd_axis.tdata;
                    s0_tid_reg  <= sd_axis.tid;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] lane_wt, lane_act;
            logic signed [PROD_W-1:0]     prod_reg;

            assign lane_wt  = s0_data_reg[gi*LANE_W+DATA_WIDTH +: DATA_WIDTH];
            assign lane_act = s0_data_reg[gi*LANE_W +: DATA_WIDTH];

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    prod_reg <= '0;
                end else if (en) begin
                    prod_reg <= PROD_W'(lane_wt) * PROD_W'(lane_act);
                end
            end

            assign s1_prod_flat[gi*PROD_W +: PROD_W] = prod_reg;
        end
    endgenerate

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_user_reg  <= 1'b0;
            s1_tid_reg   <= '0;
            s1_bias_reg  <= '0;
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_user_reg  <= 1'b0;
            s2_tid_reg   <= '0;
            s2_bias_reg  <= '0;
        end else if (en) begin
            s1_valid_reg <= s0_valid_reg;
            s1_last_reg  <= s0_last_reg;
            s1_user_reg  <= s0_user_reg;
            s1_tid_reg   <= s0_tid_reg;
            // Bias is an activation-scale value; shift it up to product scale.
            s1_bias_reg  <= PROD_W'($signed(s0_data_reg[DATA_WIDTH-1:0])) <<< FRAC_BITS;
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
            s2_user_reg  <= s1_user_reg;
            s2_tid_reg   <= s1_tid_reg;
            s2_bias_reg  <= s1_bias_reg;
        end
    end

    mac_adder_tree #(
        .IN_W   (PROD_W),
        .OUT_W  (SUM_W),
        .NUM_IN (NUM_LANES)
    ) u_tree (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .en      (en),
        .in_flat (s1_prod_flat),
        .sum_reg (s2_sum)
    );

    // First beat of a packet loads (bias or zero) instead of adding to the old total.
    always_comb begin
        acc_base = acc_reg;
        if (first_beat_reg) begin
            acc_base = s2_user_reg ? ACC_W'(s2_bias_reg) : '0;
        end
        acc_next = acc_base + ACC_W'(s2_sum);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            acc_reg        <= '0;
            first_beat_reg <= 1'b1;
            s3_valid_reg   <= 1'b0;
            s3_tid_reg     <= '0;
        end else if (en) begin
            s3_valid_reg <= s2_valid_reg && s2_last_reg;
            if (s2_valid_reg) begin
                acc_reg        <= acc_next;
                first_beat_reg <= s2_last_reg;
                if (s2_last_reg) begin
                    s3_tid_reg <= s2_tid_reg;
                end
            end
        end
    end

`ifdef STAGED_MAC_VEC_SAT_EN
    logic [ACC_W-1-OUT_MSB:0] acc_upper;
    sat_e                     sat_sel;

    assign acc_upper = acc_reg[ACC_W-1:OUT_MSB];
    assign sat_sel   = sat_kind(acc_reg[ACC_W-1], (&acc_upper) || !(|acc_upper));

    always_comb begin
        case (sat_sel)
            SAT_HI:  out_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            SAT_LO:  out_next = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            default: out_next = acc_reg[OUT_MSB:FRAC_BITS];
        endcase
    end
`else
    assign out_next = acc_reg[OUT_MSB:FRAC_BITS];
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mo_valid_reg <= 1'b0;
            mo_data_reg  <= '0;
            mo_tid_reg   <= '0;
        end else if (en) begin
            mo_valid_reg <= s3_valid_reg;
            if (s3_valid_reg) begin
                mo_data_reg <= out_next;
                mo_tid_reg  <= s3_tid_reg;
            end
        end
    end

    assign mo_axis.tvalid = mo_valid_reg;
    assign mo_axis.tdata  = mo_data_reg;
    assign mo_axis.tid    = mo_tid_reg;
    assign mo_axis.tlast  = mo_valid_reg;
    assign mo_axis.tuser  = 1'b0;

endmodule

// File: tb/tb_staged_mac_vec.sv
// Scoreboard bench for staged_mac_vec: a wide-precision model pushes expected results per packet.
`timescale 1ns/1ps
module tb_staged_mac_vec;
    import staged_mac_vec_pkg::*;

    localparam int DW   = 32;
    localparam int FRAC = 16;
    localparam int NL   = 4;
    localparam int SD_W = NL * 2 * DW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [7:0]    tid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    staged_mac_vec_if #(.DATA_W(SD_W)) sd_axis ();
    staged_mac_vec_if #(.DATA_W(DW))   mo_axis ();

    staged_mac_vec #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FRAC),
        .NUM_LANES  (NL),
        .ACCUM_BITS (8)
    ) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .sd_axis (sd_axis),
        .mo_axis (mo_axis)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int n_pushed = 0;
    int cyc      = 0;
    int last_edge = 0;
    bit lat_check = 0;
    exp_t exp_q[$];
    logic signed [127:0] m_acc = '0;
    bit m_first = 1;
    logic [DW-1:0] last_out = '0;
    bit held_v = 0;
    logic [DW-1:0] held_d;
    logic [7:0] held_t;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [127:0] beat_sum(input logic [SD_W-1:0] d);
        logic signed [127:0] s;
        logic signed [DW-1:0] w, a;
        s = '0;
        for (int i = 0; i < NL; i++) begin
            w = d[i*2*DW+DW +: DW];
            a = d[i*2*DW +: DW];
            s = s + 128'(w) * 128'(a);
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] model_out(input logic signed [127:0] acc);
        logic signed [127:0] sh;
        sh = acc >>> FRAC;
`ifdef STAGED_MAC_VEC_SAT_EN
        if (sh > 128'sd2147483647) return 32'h7FFFFFFF;
        if (sh < -128'sd2147483648) return 32'h80000000;
`endif
        return sh[DW-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model and scoreboard: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        logic signed [127:0] base;
        logic signed [DW-1:0] act0;
        exp_t e;
        if (!rst_n) begin
            m_acc   = '0;
            m_first = 1;
            held_v  = 0;
        end else begin
            if (sd_axis.tvalid && sd_axis.tready) begin
                act0 = sd_axis.tdata[DW-1:0];
                if (m_first) base = sd_axis.tuser ? (128'(act0) <<< FRAC) : '0;
                else         base = m_acc;
                m_acc   = base + beat_sum(sd_axis.tdata);
                m_first = sd_axis.tlast;
                if (sd_axis.tlast) begin
                    exp_q.push_back('{data: model_out(m_acc), tid: sd_axis.tid});
                    n_pushed++;
                    last_edge = cyc + 1;
                end
            end
            if (mo_axis.tvalid && mo_axis.tready) begin
                n_out++;
                last_out = mo_axis.tdata;
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", mo_axis.tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("out tid=%0h data=%08h exp=%08h", mo_axis.tid, mo_axis.tdata, e.data);
                    check_val("out_data", mo_axis.tdata, e.data);
                    check_val("out_tid", mo_axis.tid, e.tid);
                    check_val("out_tlast", mo_axis.tlast, 1);
                    if (lat_check) check_val("latency", cyc - last_edge, 4);
                end
            end
            if (mo_axis.tvalid && !mo_axis.tready) begin
                check_val("stall_sd_ready", sd_axis.tready, 0);
                if (held_v) begin
                    check_val("stall_data", mo_axis.tdata, held_d);
                    check_val("stall_tid", mo_axis.tid, held_t);
                end
                held_v = 1;
                held_d = mo_axis.tdata;
                held_t = mo_axis.tid;
            end else begin
                held_v = 0;
            end
        end
    end

    task automatic drive_beat(input logic [SD_W-1:0] d, input bit last, input bit user,
                              input logic [7:0] id);
        bit ok;
        ok = 0;
        sd_axis.tdata  = d;
        sd_axis.tlast  = last;
        sd_axis.tuser  = user;
        sd_axis.tid    = id;
        sd_axis.tvalid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = sd_axis.tready;
            @(posedge clk);
            #1;
        end
        if (!ok) check_val("drive_timeout", ok, 1);
        sd_axis.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        sd_axis.tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", exp_q.size(), 0);
        idle(2);
    endtask

    function automatic logic [SD_W-1:0] make_beat(input logic [DW-1:0] w0, input logic [DW-1:0] a0,
                                                  input logic [DW-1:0] w, input logic [DW-1:0] a);
        logic [SD_W-1:0] d;
        for (int i = 0; i < NL; i++) d[i*2*DW +: 2*DW] = {w, a};
        d[2*DW-1:0] = {w0, a0};
        return d;
    endfunction

    function automatic logic [SD_W-1:0] rand_beat();
        logic [SD_W-1:0] d;
        for (int i = 0; i < SD_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        int n0;
        sd_axis.tdata  = '0;
        sd_axis.tlast  = 1'b0;
        sd_axis.tuser  = 1'b0;
        sd_axis.tid    = '0;
        sd_axis.tvalid = 1'b0;
        mo_axis.tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_sd_ready", sd_axis.tready, 0);
        check_val("rst_mo_valid", mo_axis.tvalid, 0);
        check_val("rst_mo_data", mo_axis.tdata, 0);
        check_val("rst_mo_tid", mo_axis.tid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("ready_after_rst", sd_axis.tready, 1);

        // Single beat, no bias: 4 * 1.125 * 2.25 = 10.125, with 4-cycle latency.
        lat_check = 1;
        drive_beat(make_beat(32'h00012000, 32'h00024000, 32'h00012000, 32'h00024000), 1, 0, 8'h11);
        wait_drain();
        lat_check = 0;
        check_val("t1_value", last_out, 32'h000A2000);

        // Bias preload of 1.0 with lane0 activation 1.0.
        drive_beat(make_beat(32'h00012000, 32'h00010000, 32'h00012000, 32'h00024000), 1, 1, 8'h22);
        wait_drain();
        check_val("t2_value", last_out, 32'h0009B800);

        // 10-beat random packet with random gaps and random (ignored) later TUSER.
        for (int b = 0; b < 10; b++) begin
            drive_beat(rand_beat(), b == 9, $urandom_range(0, 1), 8'h33);
            idle($urandom_range(0, 2));
        end
        wait_drain();

        // Overflowing single lane.
        drive_beat(make_beat(32'h7FFF0000, 32'h7FFF0000, 32'h0, 32'h0), 1, 0, 8'h44);
        wait_drain();
`ifdef STAGED_MAC_VEC_SAT_EN
        check_val("t4_sat", last_out, 32'h7FFFFFFF);
`else
        check_val("t4_wrap", last_out, 32'h00010000);
`endif

        // Back-to-back single-beat packets: each must start a fresh accumulation.
        for (int p = 0; p < 4; p++) begin
            drive_beat(rand_beat(), 1, p[0], 8'h50 + 8'(p));
        end
        wait_drain();

        // Output backpressure while further beats are offered.
        fork
            begin
                for (int b = 0; b < 2; b++) drive_beat(rand_beat(), b == 1, 1, 8'h61);
                for (int b = 0; b < 3; b++) drive_beat(rand_beat(), b == 2, 0, 8'h62);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                mo_axis.tready = 1'b0;
                repeat (14) @(posedge clk);
                #1;
                mo_axis.tready = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of a packet discards the partial sum.
        for (int b = 0; b < 3; b++) drive_beat(rand_beat(), 0, b == 0, 8'h70);
        idle(1);
        n0 = n_out;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_sd_ready", sd_axis.tready, 0);
        check_val("midrst_mo_valid", mo_axis.tvalid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        check_val("midrst_no_output", n_out - n0, 0);
        drive_beat(rand_beat(), 0, 1, 8'h71);
        drive_beat(rand_beat(), 1, 0, 8'h71);
        wait_drain();
        check_val("post_rst_outputs", n_out - n0, 1);

        check_val("output_count", n_out, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
